// File: rtl/sample_accum_decim.sv
// Windowed accumulate-and-dump decimator: sums DECIM ce-qualified signed samples
// and emits one registered full-precision sum per window with a one-cycle strobe.
module sample_accum_decim #(
    parameter int DATA_W = 16,
    parameter int DECIM  = 4,
    parameter int OUT_W  = 18
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       ce,
    input  logic [DATA_W-1:0]          input_port,
    input  logic                       restart,
    output logic [OUT_W-1:0]           output_port,
    output logic                       out_valid,
    output logic [$clog2(DECIM)-1:0]   phase
);

    localparam int PH_W = $clog2(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    generate
        if (DECIM < 2 || DECIM > 256) begin : g_bad_decim
            $fatal(1, "sample_accum_decim: DECIM must be in 2..256");
        end
        if (OUT_W < DATA_W + $clog2(DECIM)) begin : g_bad_width
            $fatal(1, "sample_accum_decim: OUT_W too narrow for DATA_W and DECIM");
        end
    endgenerate

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [OUT_W-1:0] sample_sext;

    assign sample_sext = {{(OUT_W-DATA_W){input_port[DATA_W-1]}}, input_port};

    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        out_d   = out_q;
        valid_d = 1'b0;
        // Restart beats window completion: the sample always opens a new window.
        if (restart) begin
            phase_d = '0;
            if (ce) begin
                acc_d   = sample_sext;
                phase_d = PH_ONE;
            end
        end else if (ce) begin
            if (phase_q == '0) begin
                acc_d   = sample_sext;
                phase_d = PH_ONE;
            end else if (phase_q == PH_LAST) begin
                out_d   = acc_q + sample_sext;
                valid_d = 1'b1;
                phase_d = '0;
            end else begin
                acc_d   = acc_q + sample_sext;
                phase_d = phase_q + PH_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            acc_q   <= '0;
            phase_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign output_port = out_q;
    assign out_valid   = valid_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_sample_accum_decim.sv
// Directed-vector bench for sample_accum_decim at DECIM=4, OUT_W=18.
module tb_sample_accum_decim;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        ce = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] input_port = '0;
    logic [17:0] output_port;
    logic        out_valid;
    logic [1:0]  phase;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        clr;
        logic        ce;
        logic        rs;
        logic [15:0] din;
        logic [17:0] eout;
        logic        ev;
        logic [1:0]  eph;
    } vec_t;

    vec_t tbl[$];

    sample_accum_decim #(.DATA_W(16), .DECIM(4), .OUT_W(18)) dut (
        .clk(clk),
        .clr(clr),
        .ce(ce),
        .input_port(input_port),
        .restart(restart),
        .output_port(output_port),
        .out_valid(out_valid),
        .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic c, input logic e, input logic r,
                                input logic [15:0] d, input logic [17:0] o,
                                input logic v, input logic [1:0] p);
        vec_t t;
        t.clr = c; t.ce = e; t.rs = r; t.din = d; t.eout = o; t.ev = v; t.eph = p;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input int idx, input logic [17:0] act,
                         input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic e, input logic r, input logic [15:0] d);
        @(negedge clk);
        clr = c; ce = e; restart = r; input_port = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held with ce active, plus clr overriding restart
        add(0,1,0,16'h1234, 18'd0,0,0);
        add(0,1,0,16'h1234, 18'd0,0,0);
        add(0,1,1,16'h1234, 18'd0,0,0);
        // basic window 1..4
        add(1,1,0,16'd1, 18'd0,0,1);
        add(1,1,0,16'd2, 18'd0,0,2);
        add(1,1,0,16'd3, 18'd0,0,3);
        add(1,1,0,16'd4, 18'd10,1,0);
        add(1,0,0,16'hAAAA, 18'd10,0,0);
        // negative extreme
        add(1,1,0,16'h8000, 18'd10,0,1);
        add(1,1,0,16'h8000, 18'd10,0,2);
        add(1,1,0,16'h8000, 18'd10,0,3);
        add(1,1,0,16'h8000, 18'h20000,1,0);
        // positive extreme
        add(1,1,0,16'h7FFF, 18'h20000,0,1);
        add(1,1,0,16'h7FFF, 18'h20000,0,2);
        add(1,1,0,16'h7FFF, 18'h20000,0,3);
        add(1,1,0,16'h7FFF, 18'h1FFFC,1,0);
        // mixed signs cancel
        add(1,1,0,16'hFFFF, 18'h1FFFC,0,1);
        add(1,1,0,16'd1,    18'h1FFFC,0,2);
        add(1,1,0,16'hFFFF, 18'h1FFFC,0,3);
        add(1,1,0,16'd1,    18'd0,1,0);
        // ce gaps with garbage on the bus
        add(1,1,0,16'd5,    18'd0,0,1);
        add(1,0,0,16'hDEAD, 18'd0,0,1);
        add(1,1,0,16'd5,    18'd0,0,2);
        add(1,0,0,16'hBEEF, 18'd0,0,2);
        add(1,1,0,16'd5,    18'd0,0,3);
        add(1,0,0,16'h7777, 18'd0,0,3);
        add(1,1,0,16'd5,    18'd20,1,0);
        add(1,0,0,16'h5555, 18'd20,0,0);
        // restart without a sample
        add(1,1,0,16'd7, 18'd20,0,1);
        add(1,1,0,16'd7, 18'd20,0,2);
        add(1,0,1,16'd7, 18'd20,0,0);
        add(1,1,0,16'd1, 18'd20,0,1);
        add(1,1,0,16'd1, 18'd20,0,2);
        add(1,1,0,16'd1, 18'd20,0,3);
        add(1,1,0,16'd1, 18'd4,1,0);
        // restart on what would be the completing sample
        add(1,1,0,16'd7, 18'd4,0,1);
        add(1,1,0,16'd7, 18'd4,0,2);
        add(1,1,0,16'd7, 18'd4,0,3);
        add(1,1,1,16'd9, 18'd4,0,1);
        add(1,1,0,16'd1, 18'd4,0,2);
        add(1,1,0,16'd1, 18'd4,0,3);
        add(1,1,0,16'd1, 18'd12,1,0);
        // reset mid-window
        add(1,1,0,16'd3, 18'd12,0,1);
        add(1,1,0,16'd3, 18'd12,0,2);
        add(1,1,0,16'd3, 18'd12,0,3);
        add(0,1,0,16'd3, 18'd0,0,0);
        add(1,1,0,16'd2, 18'd0,0,1);
        add(1,1,0,16'd2, 18'd0,0,2);
        add(1,1,0,16'd2, 18'd0,0,3);
        add(1,1,0,16'd2, 18'd8,1,0);
        add(1,0,0,16'd0, 18'd8,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].ce, tbl[i].rs, tbl[i].din);
            check("output_port", i, output_port, tbl[i].eout);
            check("out_valid", i, {17'd0, out_valid}, {17'd0, tbl[i].ev});
            check("phase", i, {16'd0, phase}, {16'd0, tbl[i].eph});
        end

        // back-to-back windows at full rate: samples 1..12 give sums 10, 26, 42
        begin
            int sum = 0;
            int strobes = 0;
            logic prev_v = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                step(1, 1, 0, 16'(k));
                sum += k;
                check("stream_valid", 100 + k, {17'd0, out_valid}, {17'd0, (k % 4 == 0)});
                check("stream_phase", 100 + k, {16'd0, phase}, 18'(k % 4));
                if (out_valid) begin
                    strobes++;
                    check("stream_sum", 100 + k, output_port, 18'(sum));
                    sum = 0;
                end
                check("no_back_to_back", 100 + k, {17'd0, prev_v & out_valid}, 18'd0);
                prev_v = out_valid;
            end
            step(1, 0, 0, 16'hFFFF);
            check("stream_idle_valid", 113, {17'd0, out_valid}, 18'd0);
            check("stream_hold", 113, output_port, 18'd42);
            check("stream_strobes", 114, 18'(strobes), 18'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_accum_decim.md
Name: sample_accum_decim

Overview:
- Downstream consumer of the 16-bit signed sample word produced by the pass-through/cast stage.
- Accumulates DECIM consecutive ce-qualified samples into a full-precision signed sum.
- Emits one registered result per window with a single-cycle valid strobe, decimating the stream by DECIM.
- Feeds the rate-reduced filter/scaling stages that follow.

Parameters:
- DATA_W, 16, width of input_port; input is interpreted as two's-complement signed.
- DECIM, 4, samples per window; legal range 2..256.
- OUT_W, 18, width of output_port; must satisfy OUT_W >= DATA_W + clog2(DECIM), checked at elaboration (fatal if violated).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- ce  input  1  clock enable / sample strobe; input_port is consumed only on cycles with ce=1.
- input_port  input  DATA_W  signed sample.
- restart  input  1  synchronous window restart (frame alignment).
- output_port  output  OUT_W  signed window sum, registered.
- out_valid  output  1  one-cycle strobe marking a new output_port value.
- phase  output  clog2(DECIM)  number of samples already accumulated in the current window.

Behaviour:
- Reset (clr=0 at a clk edge):
  - acc=0, phase=0, output_port=0, out_valid=0.
  - clr overrides ce and restart.
  - Mid-window reset discards the partial sum; no output is produced for that partial window.
- Sign-extension: each sample is sign-extended from DATA_W to OUT_W before addition. No saturation or wrap is possible given the OUT_W constraint.
- ce=1, restart=0, phase=0: acc <= sext(in), phase <= 1.
- ce=1, restart=0, 0<phase<DECIM-1: acc <= acc + sext(in), phase <= phase+1.
- ce=1, restart=0, phase=DECIM-1 (window complete):
  - output_port <= acc + sext(in), out_valid <= 1, phase <= 0.
  - acc value is don't-care; the next accepted sample overwrites it.
- ce=0, restart=0: acc, phase and output_port hold; input_port is ignored.
- restart=1 with ce=0: phase <= 0; the partial window is discarded; no output.
- restart=1 with ce=1: the current sample starts a new window: acc <= sext(in), phase <= 1; no output for the discarded partial.
  - Exception: if DECIM samples have arrived exactly, i.e. the restart sample would complete the window, restart still wins. The sample becomes the first of the new window and no output is produced.
- out_valid:
  - High for exactly one clk cycle, the cycle after the edge on which the final sample was accepted.
  - Low on every other cycle, including cycles with ce=0.
  - Never high two cycles in a row unless DECIM samples arrive between strobes (impossible for DECIM >= 2).
- output_port holds its last value between strobes.
- Latency: final sample at edge N -> output_port/out_valid visible after edge N; one register stage, no combinational path from input_port to output_port.
- Throughput: one sample per clock with ce held high; one output per DECIM accepted samples.
- phase wraps DECIM-1 -> 0 only on window completion or restart; it never reaches DECIM.

Test Plan:
- Reset: hold clr=0 three cycles with ce=1, input_port=16'h1234 -> output_port=0, out_valid=0, phase=0 throughout; first sample after clr=1 gives phase=1.
- Basic window (DECIM=4, OUT_W=18): ce=1, samples 1,2,3,4 -> after 4th edge output_port=18'd10, out_valid=1 for one cycle; phase sequence 1,2,3,0.
- Signed extremes: four samples 16'h8000 -> output_port=18'h20000 (-131072); then four samples 16'h7FFF -> 18'h1FFFC (131068); mixed 16'hFFFF,1,16'hFFFF,1 -> 0.
- ce gaps: samples 5,5,5,5 with ce=0 idle cycles between each, input_port toggling garbage while ce=0 -> output_port=18'd20, one out_valid, strobe one cycle after 4th accepted sample.
- Restart: samples 7,7 then restart=1 with ce=0, then 1,1,1,1 -> single output 18'd4; repeat with restart=1,ce=1 on sample 9 after three 7s, then 1,1,1 -> output 18'd12, no output containing 7s.
- Reset mid-window: samples 3,3,3, clr=0 for one cycle, then four samples of 2 -> output_port=18'd8, exactly one out_valid after reset.
